// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector (Mealy).
// Keeps the last PAT_W-1 accepted bits and compares them, together with the
// current input bit, against a run-time loadable pattern. Supports overlapping
// and non-overlapping detection, a registered copy of the match and a
// saturating match counter.
module seq_detector_prog #(
  parameter int              PAT_W     = 4,
  parameter int              CNT_W     = 8,
  parameter logic [PAT_W-1:0] RESET_PAT = 4'b1101
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic             din,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap_en,
  input  logic             cnt_clr,
  output logic             match,
  output logic             match_q,
  output logic [CNT_W-1:0] match_cnt
);

  // History fill level spans 0..PAT_W-1.
  localparam int               FILL_W    = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  generate
    if (PAT_W < 2 || PAT_W > 32) begin : g_bad_pat_w
      $error("seq_detector_prog: PAT_W must be within 2..32");
    end
  endgenerate

  logic [PAT_W-1:0]  pat_r;
  logic [PAT_W-2:0]  hist_r;
  logic [FILL_W-1:0] fill_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              match_q_r;

  logic [PAT_W-1:0]  window_s;
  logic              match_s;
  logic [PAT_W-1:0]  pat_nxt_s;
  logic [PAT_W-2:0]  hist_nxt_s;
  logic [FILL_W-1:0] fill_nxt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;

  // Candidate window: stored history with the current bit as the newest.
  assign window_s = {hist_r, din};

  // Mealy match: only on an accepted bit with a full history.
  always_comb begin
    match_s = 1'b0;
    if (din_valid && !pat_load && (fill_r == FILL_FULL) && (window_s == pat_r)) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
  end

  // Next pattern, history and fill level; a load restarts history collection.
  always_comb begin
    pat_nxt_s  = pat_r;
    hist_nxt_s = hist_r;
    fill_nxt_s = fill_r;
    if (pat_load) begin
      pat_nxt_s  = pattern;
      fill_nxt_s = '0;
    end else if (din_valid) begin
      hist_nxt_s = window_s[PAT_W-2:0];
      if (match_s && !overlap_en) begin
        fill_nxt_s = '0;
      end else if (fill_r == FILL_FULL) begin
        fill_nxt_s = fill_r;
      end else begin
        fill_nxt_s = fill_r + FILL_W'(1);
      end
    end else begin
      hist_nxt_s = hist_r;
      fill_nxt_s = fill_r;
    end
  end

  // Match counter: clear has priority but still counts a coincident match.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (cnt_clr) begin
      if (match_s) begin
        cnt_nxt_s = CNT_W'(1);
      end else begin
        cnt_nxt_s = '0;
      end
    end else if (match_s) begin
      if (cnt_r == CNT_MAX) begin
        cnt_nxt_s = cnt_r;
      end else begin
        cnt_nxt_s = cnt_r + CNT_W'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // State registers with asynchronous reset back to the reset pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_r     <= RESET_PAT;
      hist_r    <= '0;
      fill_r    <= '0;
      cnt_r     <= '0;
      match_q_r <= 1'b0;
    end else begin
      pat_r     <= pat_nxt_s;
      hist_r    <= hist_nxt_s;
      fill_r    <= fill_nxt_s;
      cnt_r     <= cnt_nxt_s;
      match_q_r <= match_s;
    end
  end

  assign match     = match_s;
  assign match_q   = match_q_r;
  assign match_cnt = cnt_r;

endmodule
